// File: rtl/cam_line_packer.sv
// Camera line packer: packs accepted pixels into PACK_N-wide words, queues
// them in a DEPTH-word FIFO and raises sticky threshold/frame-end/overflow
// causes that drive a registered, maskable interrupt line.
module cam_line_packer #(
  parameter int PIX_W  = 16,
  parameter int PACK_N = 2,
  parameter int DEPTH  = 64,
  parameter int THRESH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_pix_valid,
  input  logic [PIX_W-1:0]          i_pix_data,
  input  logic                      i_href,
  input  logic                      i_vsync,
  input  logic                      i_rd_en,
  output logic [PIX_W*PACK_N-1:0]   o_rd_data,
  output logic                      o_rd_valid,
  output logic [$clog2(DEPTH):0]    o_level,
  input  logic [2:0]                i_irq_en,
  input  logic                      i_clr_valid,
  input  logic [2:0]                i_clr_mask,
  output logic [2:0]                o_cause,
  output logic                      o_interrupt
);

  localparam int WW = PIX_W * PACK_N;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int KW = (PACK_N > 1) ? $clog2(PACK_N) : 1;

  logic          href_q, vsync_q;
  logic          vs_rise, hr_fall, accept;
  logic [KW-1:0] k;
  logic [WW-1:0] acc, acc_ins;
  logic          pend;
  logic [WW-1:0] pend_word;

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] count, count_next;
  logic          do_push, do_pop, ovf, thr_hit;
  logic [2:0]    set_ev, clr_bits;

  assign vs_rise = i_vsync & ~vsync_q;
  assign hr_fall = href_q & ~i_href;
  assign accept  = i_pix_valid & i_href;

  // Edge-detect history for href and vsync.
  always_ff @(posedge clk) begin
    if (rst) begin
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      href_q  <= i_href;
      vsync_q <= i_vsync;
    end
  end

  // Accumulator with the incoming pixel dropped into slot k.
  always_comb begin
    acc_ins = acc;
    acc_ins[int'(k)*PIX_W +: PIX_W] = i_pix_data;
  end

  // Packer: vsync discards the partial word (and any pixel arriving with it);
  // a full word or an href-fall flush becomes a push one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      pend_word <= '0;
    end else begin
      pend <= 1'b0;
      if (vs_rise) begin
        k   <= '0;
        acc <= '0;
      end else if (accept) begin
        if (k == KW'(PACK_N - 1)) begin
          pend      <= 1'b1;
          pend_word <= acc_ins;
          k         <= '0;
          acc       <= '0;
        end else begin
          acc <= acc_ins;
          k   <= k + KW'(1);
        end
      end else if (hr_fall && k != '0) begin
        pend      <= 1'b1;
        pend_word <= acc;
        k         <= '0;
        acc       <= '0;
      end
    end
  end

  assign do_pop  = i_rd_en && (count != '0);
  assign do_push = pend && ((count < LW'(DEPTH)) || i_rd_en);
  assign ovf     = pend && !do_push;

  // Next fill level from the push/pop pair.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + LW'(1);
    else if (!do_push && do_pop)
      count_next = count - LW'(1);
  end

  assign thr_hit = (count == LW'(THRESH - 1)) && (count_next == LW'(THRESH));

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= pend_word;
  end

  // FIFO pointers, level and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      count      <= count_next;
      o_rd_valid <= do_pop;
      if (do_pop) begin
        o_rd_data <= mem[rptr];
        rptr      <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      end
      if (do_push)
        wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
    end
  end

  assign o_level  = count;
  assign set_ev   = {ovf, vs_rise, thr_hit};
  assign clr_bits = i_clr_valid ? i_clr_mask : 3'b000;

  // Sticky causes (set beats clear) and the registered interrupt line.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cause     <= '0;
      o_interrupt <= 1'b0;
    end else begin
      o_cause     <= (o_cause & ~clr_bits) | set_ev;
      o_interrupt <= |(o_cause & i_irq_en);
    end
  end

endmodule

// File: tb/tb_cam_line_packer.sv
// Self-checking bench for cam_line_packer: a queue-based reference model
// checked on every cycle, directed scenarios with literal expectations,
// then randomized traffic.
module tb_cam_line_packer;

  localparam int PIX_W  = 16;
  localparam int PACK_N = 2;
  localparam int DEPTH  = 8;
  localparam int THRESH = 4;
  localparam int WW     = PIX_W * PACK_N;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pix_valid;
  logic [PIX_W-1:0]  i_pix_data;
  logic              i_href;
  logic              i_vsync;
  logic              i_rd_en;
  logic [WW-1:0]     o_rd_data;
  logic              o_rd_valid;
  logic [3:0]        o_level;
  logic [2:0]        i_irq_en;
  logic              i_clr_valid;
  logic [2:0]        i_clr_mask;
  logic [2:0]        o_cause;
  logic              o_interrupt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  cam_line_packer #(.PIX_W(PIX_W), .PACK_N(PACK_N), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
    .i_href(i_href), .i_vsync(i_vsync), .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_level(o_level), .i_irq_en(i_irq_en),
    .i_clr_valid(i_clr_valid), .i_clr_mask(i_clr_mask), .o_cause(o_cause),
    .o_interrupt(o_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WW-1:0]    fq[$];
  logic [PIX_W-1:0] pq[$];
  bit               m_pend, m_hp, m_vp, m_irq, m_rdv;
  logic [WW-1:0]    m_pw, m_rdd;
  logic [2:0]       m_cause;

  function automatic logic [WW-1:0] pack_partial();
    logic [WW-1:0] w = '0;
    for (int unsigned i = 0; i < pq.size(); i++)
      w[i*PIX_W +: PIX_W] = pq[i];
    return w;
  endfunction

  // Model advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    bit rise, fall;
    int lvl0;
    logic [2:0] set;
    if (rst) begin
      fq.delete(); pq.delete();
      m_pend = 0; m_hp = 0; m_vp = 0; m_irq = 0; m_rdv = 0;
      m_rdd = '0; m_pw = '0; m_cause = '0;
    end else begin
      rise = i_vsync && !m_vp;
      fall = m_hp && !i_href;
      set  = '0;
      lvl0 = fq.size();
      m_irq = |(m_cause & i_irq_en);
      if (i_rd_en && lvl0 > 0) begin
        m_rdd = fq.pop_front();
        m_rdv = 1;
      end else m_rdv = 0;
      if (m_pend) begin
        if (lvl0 < DEPTH || i_rd_en) fq.push_back(m_pw);
        else set[2] = 1'b1;
      end
      if (lvl0 == THRESH - 1 && fq.size() == THRESH) set[0] = 1'b1;
      m_pend = 0;
      if (rise) begin
        set[1] = 1'b1;
        pq.delete();
      end else if (i_pix_valid && i_href) begin
        pq.push_back(i_pix_data);
        if (pq.size() == PACK_N) begin
          m_pw = pack_partial(); m_pend = 1; pq.delete();
        end
      end else if (fall && pq.size() > 0) begin
        m_pw = pack_partial(); m_pend = 1; pq.delete();
      end
      m_cause = (m_cause & ~(i_clr_valid ? i_clr_mask : 3'b000)) | set;
      m_hp = i_href;
      m_vp = i_vsync;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rd_valid", 32'(o_rd_valid), 32'(m_rdv));
      chk("m_rd_data", o_rd_data, m_rdd);
      chk("m_level", 32'(o_level), 32'(fq.size()));
      chk("m_cause", 32'(o_cause), 32'(m_cause));
      chk("m_interrupt", 32'(o_interrupt), 32'(m_irq));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input int n, input logic [15:0] base, input logic [15:0] inc);
    i_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_pix_valid = 1'b1;
      i_pix_data  = base + 16'(i) * inc;
      step();
    end
    i_pix_valid = 1'b0;
    i_href      = 1'b0;
    step(4);
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] exp);
    i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0;
    chk({nm, "_valid"}, 32'(o_rd_valid), 32'd1);
    chk(nm, o_rd_data, exp);
  endtask

  task automatic clear_all();
    i_clr_valid = 1'b1;
    i_clr_mask  = 3'b111;
    step();
    i_clr_valid = 1'b0;
    i_clr_mask  = 3'b000;
    step(2);
  endtask

  initial begin
    int rdp;
    rst = 1'b1; i_pix_valid = 0; i_pix_data = '0; i_href = 0; i_vsync = 0;
    i_rd_en = 0; i_irq_en = 3'b000; i_clr_valid = 0; i_clr_mask = '0;
    step();
    chk_en = 1'b1;
    chk("rst_level", 32'(o_level), 0);
    chk("rst_cause", 32'(o_cause), 0);
    chk("rst_valid", 32'(o_rd_valid), 0);
    rst = 1'b0;
    step(2);

    // Full-line packing, three words in order.
    send_line(6, 16'h0001, 16'h0001);
    chk("pack_level3", 32'(o_level), 3);
    pop_chk("pack_w0", 32'h00020001);
    pop_chk("pack_w1", 32'h00040003);
    pop_chk("pack_w2", 32'h00060005);
    step();
    chk("pack_level0", 32'(o_level), 0);
    i_rd_en = 1'b1; step(); i_rd_en = 1'b0;
    chk("empty_pop_valid", 32'(o_rd_valid), 0);
    chk("empty_pop_hold", o_rd_data, 32'h00060005);

    // Partial flush on href fall.
    send_line(3, 16'hAAAA, 16'h1111);
    pop_chk("flush_w0", 32'hBBBBAAAA);
    pop_chk("flush_w1", 32'h0000CCCC);
    step();

    // Threshold crossing and clear.
    i_irq_en = 3'b001;
    send_line(8, 16'h1000, 16'h0001);
    chk("thr_level", 32'(o_level), 4);
    chk("thr_cause0", 32'(o_cause[0]), 1);
    chk("thr_irq", 32'(o_interrupt), 1);
    i_clr_valid = 1'b1; i_clr_mask = 3'b001; step();
    i_clr_valid = 1'b0; i_clr_mask = 3'b000; step(2);
    chk("thr_irq_clr", 32'(o_interrupt), 0);
    send_line(2, 16'h2000, 16'h0001);
    chk("thr_level5", 32'(o_level), 5);
    chk("thr_no_reset", 32'(o_cause[0]), 0);
    i_rd_en = 1'b1; step(5); i_rd_en = 1'b0; step(2);

    // Overflow: nine words into an eight-deep FIFO.
    send_line(18, 16'h0100, 16'h0001);
    chk("ovf_level", 32'(o_level), 8);
    chk("ovf_cause2", 32'(o_cause[2]), 1);
    for (int w = 0; w < 8; w++)
      pop_chk("ovf_word", {16'h0100 + 16'(2*w + 1), 16'h0100 + 16'(2*w)});
    step();
    clear_all();

    // Ninth push with a pop in the same cycle is accepted.
    send_line(16, 16'h0300, 16'h0001);
    i_href = 1'b1;
    i_pix_valid = 1'b1; i_pix_data = 16'h0EEE; step();
    i_pix_data = 16'h0FFF; step();
    i_pix_valid = 1'b0; i_rd_en = 1'b1; step();
    i_rd_en = 1'b0; i_href = 1'b0; step(3);
    chk("simul_no_ovf", 32'(o_cause[2]), 0);
    chk("simul_level", 32'(o_level), 8);
    i_rd_en = 1'b1; step(8); i_rd_en = 1'b0; step(2);
    clear_all();

    // vsync rise beats a simultaneous clear of the same bit.
    i_vsync = 1'b1; i_clr_valid = 1'b1; i_clr_mask = 3'b010; step();
    i_clr_valid = 1'b0; i_clr_mask = 3'b000;
    chk("vs_set_wins", 32'(o_cause[1]), 1);
    i_vsync = 1'b0; step(2);
    clear_all();

    // Reset mid-line discards stored and partial data.
    send_line(2, 16'h0055, 16'h0001);
    i_href = 1'b1; i_pix_valid = 1'b1; i_pix_data = 16'h0077; step();
    rst = 1'b1; i_pix_valid = 1'b0; i_href = 1'b0; step();
    chk("rstm_level", 32'(o_level), 0);
    chk("rstm_data", o_rd_data, 0);
    chk("rstm_valid", 32'(o_rd_valid), 0);
    chk("rstm_cause", 32'(o_cause), 0);
    chk("rstm_irq", 32'(o_interrupt), 0);
    rst = 1'b0; step();
    send_line(2, 16'h0011, 16'h0011);
    pop_chk("rstm_word", 32'h00220011);
    step(2);

    // Randomized traffic.
    rdp = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rdp = (c % 1500 == 0) ? 20 : ((c % 1000 == 0) ? 90 : 50);
      if (c % 64 == 0) i_irq_en = 3'($urandom);
      i_pix_valid = ($urandom % 4) != 0;
      i_pix_data  = 16'($urandom);
      if ($urandom % 20 == 0) i_href = ~i_href;
      if ($urandom % 60 == 0) i_vsync = ~i_vsync;
      i_rd_en     = ($urandom % 100) < rdp;
      i_clr_valid = ($urandom % 16) == 0;
      i_clr_mask  = 3'($urandom);
      rst         = ($urandom % 700) == 0;
      step();
    end
    rst = 1'b0; i_pix_valid = 0; i_href = 0; i_vsync = 0; i_rd_en = 0; i_clr_valid = 0;
    step(3);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
